// File: rtl/fetch_stage.sv
// Rx32 instruction-fetch stage with IF/ID pipeline register.
// Keeps at most one memory request in flight and squashes wrong-path responses after a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcM,
    input  logic [31:0] PCBranchM,
    input  logic        JumpM,
    input  logic [31:0] PCJumpM,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [5:0]  OPCodeD,
    output logic [5:0]  functD
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic [31:0] deliver_word;

    assign redirect   = JumpM | PCSrcM;
    assign raw_target = JumpM ? PCJumpM : PCBranchM;
    assign target     = raw_target & ~32'h3;
    assign pc_plus4   = pcf_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        req_addr_d   = req_addr_q;
        hold_buf_d   = hold_buf_q;
        deliver      = 1'b0;
        deliver_word = 32'h0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redirect) begin
                    pcf_d      = target;
                    req_addr_d = target;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    pcf_d = target;
                    if (ImemValid) begin
                        req_addr_d = target;
                    end else begin
                        // Request still in flight: keep it stable and discard its answer.
                        state_d = S_DROP;
                    end
                end else if (ImemValid) begin
                    if (!StallD) begin
                        deliver      = 1'b1;
                        deliver_word = ImemRData;
                        pcf_d        = pc_plus4;
                        req_addr_d   = pc_plus4;
                    end else begin
                        hold_buf_d = ImemRData;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pcf_d      = target;
                    req_addr_d = target;
                    hold_buf_d = 32'h0;
                    state_d    = S_FETCH;
                end else if (!StallD) begin
                    deliver      = 1'b1;
                    deliver_word = hold_buf_q;
                    pcf_d        = pc_plus4;
                    req_addr_d   = pc_plus4;
                    state_d      = S_FETCH;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pcf_d = target;
                end
                if (ImemValid) begin
                    req_addr_d = redirect ? target : pcf_q;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // IF/ID register: squash beats stall, stall beats delivery, otherwise a bubble.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (redirect || FlushD) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (StallD) begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else if (deliver) begin
            instr_d = deliver_word;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end else begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pcf_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_buf_q <= 32'h0;
            instr_q    <= 32'h0;
            pc4_q      <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            req_addr_q <= req_addr_d;
            hold_buf_q <= hold_buf_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

    assign ImemReq  = (state_q == S_FETCH) || (state_q == S_DROP);
    assign ImemAddr = req_addr_q;
    assign InstrD   = instr_q;
    assign PCPlus4D = pc4_q;
    assign ValidD   = valid_q;
    assign OPCodeD  = instr_q[31:26];
    assign functD   = instr_q[5:0];

endmodule
